// File: rtl/servo_motion_scheduler.sv
// Four-joint servo sequencer: maps finger counts to poses, steps one joint at a time under round-robin grant.
// Optional SAFE_HOME_EN: reload the home pose after LOSS_TIMEOUT cycles of continuous hand loss.
module servo_motion_scheduler #(
  parameter int unsigned STEP_PERIOD  = 65536,
  parameter int unsigned LOSS_TIMEOUT = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] finger_count,
  input  logic       count_valid,
  input  logic       hand_detected,
  input  logic       hold,
  output logic [7:0] angle_base,
  output logic [7:0] angle_shoulder,
  output logic [7:0] angle_elbow,
  output logic [7:0] angle_gripper,
  output logic       busy,
  output logic [1:0] active_servo,
  output logic       pose_done
);

  typedef enum logic [1:0] {IDLE, SELECT, STEP} state_t;

  state_t      state;
  logic [7:0]  angle  [4];
  logic [7:0]  target [4];
  logic [1:0]  last_grant;
  logic [31:0] timer;
  logic [31:0] pose;
  logic        load_pose;
  logic        home_req;
  logic        mismatch_any;
  logic        scan_hit;
  logic [1:0]  scan_grant;

  // Packed {base, shoulder, elbow, gripper}; counts outside the table map to home.
  function automatic logic [31:0] pose_of(input logic [2:0] c);
    case (c)
      3'd1:    pose_of = {8'd45,  8'd90,  8'd90,  8'd90};
      3'd2:    pose_of = {8'd135, 8'd90,  8'd90,  8'd90};
      3'd3:    pose_of = {8'd90,  8'd60,  8'd120, 8'd90};
      3'd4:    pose_of = {8'd90,  8'd120, 8'd60,  8'd90};
      3'd5:    pose_of = {8'd90,  8'd90,  8'd90,  8'd30};
      default: pose_of = {8'd90,  8'd90,  8'd90,  8'd90};
    endcase
  endfunction

`ifdef SAFE_HOME_EN
  logic [31:0] loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (hand_detected) begin
      loss_cnt <= '0;
    end else if (loss_cnt != LOSS_TIMEOUT) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  // Fires only on the edge the counter reaches the limit, so home loads once per loss.
  assign home_req = !hand_detected && (loss_cnt == LOSS_TIMEOUT - 1);
`else
  assign home_req = 1'b0;
`endif

  assign load_pose = (count_valid && hand_detected && (finger_count <= 3'd5)) || home_req;
  assign pose      = home_req ? pose_of(3'd0) : pose_of(finger_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < 4; j++) target[j] <= 8'd90;
    end else if (load_pose) begin
      target[0] <= pose[31:24];
      target[1] <= pose[23:16];
      target[2] <= pose[15:8];
      target[3] <= pose[7:0];
    end
  end

  // Round-robin scan beginning one past the last grant; offset 4 wraps back to the last grant itself.
  always_comb begin
    scan_hit     = 1'b0;
    scan_grant   = '0;
    mismatch_any = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!scan_hit && (angle[last_grant + k[1:0]] != target[last_grant + k[1:0]])) begin
        scan_hit   = 1'b1;
        scan_grant = last_grant + k[1:0];
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      if (angle[j] != target[j]) mismatch_any = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      active_servo <= '0;
      pose_done    <= 1'b0;
      last_grant   <= 2'd3;
      timer        <= '0;
      for (int unsigned j = 0; j < 4; j++) angle[j] <= 8'd90;
    end else begin
      pose_done <= 1'b0;
      if (!hold) begin
        case (state)
          IDLE: begin
            if (mismatch_any) begin
              state <= SELECT;
              busy  <= 1'b1;
            end
          end
          SELECT: begin
            if (scan_hit) begin
              state        <= STEP;
              active_servo <= scan_grant;
              last_grant   <= scan_grant;
              timer        <= '0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              pose_done <= 1'b1;
            end
          end
          STEP: begin
            if (angle[active_servo] == target[active_servo]) begin
              state <= SELECT;
              timer <= '0;
            end else if (timer == STEP_PERIOD - 1) begin
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
              // Angle moves on the edge where the timer becomes STEP_PERIOD-1.
              if (timer == STEP_PERIOD - 2) begin
                if (angle[active_servo] < target[active_servo])
                  angle[active_servo] <= angle[active_servo] + 1'b1;
                else
                  angle[active_servo] <= angle[active_servo] - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign angle_base     = angle[0];
  assign angle_shoulder = angle[1];
  assign angle_elbow    = angle[2];
  assign angle_gripper  = angle[3];

endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Scoreboard bench for servo_motion_scheduler: expected {joint, angle} changes are queued per move and
// popped by a monitor as the outputs change.
module tb_servo_motion_scheduler;
  localparam int unsigned P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] finger_count = '0;
  logic       count_valid = 1'b0;
  logic       hand_detected = 1'b1;
  logic       hold = 1'b0;
  logic [7:0] angle_base, angle_shoulder, angle_elbow, angle_gripper;
  logic       busy, pose_done;
  logic [1:0] active_servo;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];
  logic [7:0] prev  [4] = '{8'd90, 8'd90, 8'd90, 8'd90};
  logic [7:0] m_ang [4] = '{8'd90, 8'd90, 8'd90, 8'd90};
  int         m_last = 3;

  servo_motion_scheduler #(.STEP_PERIOD(P), .LOSS_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .finger_count(finger_count), .count_valid(count_valid),
    .hand_detected(hand_detected), .hold(hold), .angle_base(angle_base),
    .angle_shoulder(angle_shoulder), .angle_elbow(angle_elbow), .angle_gripper(angle_gripper),
    .busy(busy), .active_servo(active_servo), .pose_done(pose_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: every angle change must be the next scoreboard entry, on the granted joint, alone in its cycle.
  always @(negedge clk) begin
    logic [7:0] cur [4];
    int nchg;
    cur[0] = angle_base; cur[1] = angle_shoulder; cur[2] = angle_elbow; cur[3] = angle_gripper;
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) prev[j] = 8'd90;
    end else begin
      nchg = 0;
      for (int j = 0; j < 4; j++) begin
        if (cur[j] !== prev[j]) begin
          logic [9:0] e;
          nchg++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: joint %0d got %0d, required no change", j, cur[j]);
          end else begin
            e = exp_q.pop_front();
            if ({j[1:0], cur[j]} !== e) begin
              errors++;
              $display("FAIL step_value: joint %0d angle %0d, required joint %0d angle %0d",
                       j, cur[j], e[9:8], e[7:0]);
            end
          end
          checks++;
          if (active_servo !== j[1:0]) begin
            errors++;
            $display("FAIL grant_match: active_servo %0d, required %0d", active_servo, j);
          end
        end
        prev[j] = cur[j];
      end
      if (nchg > 0) begin
        checks++;
        if (nchg > 1) begin
          errors++;
          $display("FAIL single_change: %0d angles changed, required 1", nchg);
        end
      end
    end
  end

  function automatic logic [31:0] pose_of(input int c);
    case (c)
      1:       return {8'd45,  8'd90,  8'd90,  8'd90};
      2:       return {8'd135, 8'd90,  8'd90,  8'd90};
      3:       return {8'd90,  8'd60,  8'd120, 8'd90};
      4:       return {8'd90,  8'd120, 8'd60,  8'd90};
      5:       return {8'd90,  8'd90,  8'd90,  8'd30};
      default: return {8'd90,  8'd90,  8'd90,  8'd90};
    endcase
  endfunction

  // Model of a full move from idle: round-robin over mismatched joints, each walked 1 degree at a time.
  task automatic push_move(input int c);
    logic [31:0] p;
    logic [7:0] t [4];
    int j;
    p = pose_of(c);
    t[0] = p[31:24]; t[1] = p[23:16]; t[2] = p[15:8]; t[3] = p[7:0];
    forever begin
      j = -1;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (j < 0 && m_ang[idx] != t[idx]) j = idx;
      end
      if (j < 0) break;
      while (m_ang[j] != t[j]) begin
        m_ang[j] = (m_ang[j] < t[j]) ? m_ang[j] + 8'd1 : m_ang[j] - 8'd1;
        exp_q.push_back({j[1:0], m_ang[j]});
      end
      m_last = j;
    end
  endtask

  task automatic pulse_count(input logic [2:0] c, input logic hand);
    @(negedge clk);
    finger_count  = c;
    count_valid   = 1'b1;
    hand_detected = hand;
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen = 0;
    int n = 0;
    while ((busy || seen == 0) && n < 3000) begin
      @(negedge clk);
      n++;
      if (pose_done) seen++;
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL %s_done: pose_done pulses %0d, required 1", name, seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_complete: %0d steps missing, required 0", name, exp_q.size());
    end
    checks++;
    if ({angle_base, angle_shoulder, angle_elbow, angle_gripper} !==
        {m_ang[0], m_ang[1], m_ang[2], m_ang[3]}) begin
      errors++;
      $display("FAIL %s_final: angles %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d", name,
               angle_base, angle_shoulder, angle_elbow, angle_gripper,
               m_ang[0], m_ang[1], m_ang[2], m_ang[3]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({angle_base, angle_shoulder, angle_elbow, angle_gripper} !== {4{8'd90}}) begin
      errors++;
      $display("FAIL reset_angles: %0d/%0d/%0d/%0d, required 90/90/90/90",
               angle_base, angle_shoulder, angle_elbow, angle_gripper);
    end
    checks++;
    if ({busy, pose_done, active_servo} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy %b pose_done %b active %0d, required 0 0 0",
               busy, pose_done, active_servo);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || pose_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL reset_idle: busy %b pose_done %b at cycle %0d, required 0 0", busy, pose_done, i);
        break;
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_end: busy %b, required 0", busy);
    end
  endtask

  task automatic test_single_joint();
    int done_cyc = -1, done_n = 0, first_chg = -1, last_chg = -1, bad_gap = 0, nchg = 0;
    logic [7:0] pb;
    push_move(1);
    pulse_count(3'd1, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_edge_n: busy %b, required 0", busy);
    end
    pb = angle_base;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_rise: busy %b at N+1, required 1", busy);
        end
      end
      if (angle_base !== pb) begin
        nchg++;
        if (first_chg < 0) first_chg = cyc;
        else if (cyc - last_chg != int'(P)) bad_gap++;
        last_chg = cyc;
        pb = angle_base;
      end
      if (pose_done) begin
        done_n++;
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_fall: busy %b with pose_done, required 0", busy);
        end
      end
    end
    checks++;
    if (first_chg != 5 || nchg != 45 || bad_gap != 0) begin
      errors++;
      $display("FAIL step_timing: first %0d count %0d bad gaps %0d, required 5 45 0", first_chg, nchg, bad_gap);
    end
    checks++;
    if (done_n != 1 || done_cyc != 183) begin
      errors++;
      $display("FAIL done_timing: %0d pulses at N+%0d, required 1 at N+183", done_n, done_cyc);
    end
    checks++;
    if (exp_q.size() != 0 || angle_base !== 8'd45) begin
      errors++;
      $display("FAIL base_final: base %0d, required 45", angle_base);
    end
  endtask

  task automatic test_round_robin();
    push_move(0);
    pulse_count(3'd0, 1'b1);
    wait_done("home");
    push_move(3);
    pulse_count(3'd3, 1'b1);
    wait_done("pose3");
    checks++;
    if (active_servo !== 2'd2) begin
      errors++;
      $display("FAIL rr_last_grant: active_servo %0d, required 2", active_servo);
    end
  endtask

  task automatic wait_base(input logic [7:0] v, input string name);
    int n = 0;
    while (angle_base !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (angle_base !== v) begin
      errors++;
      $display("FAIL %s: base %0d, required %0d", name, angle_base, v);
    end
  endtask

  task automatic test_retarget_hold();
    logic [7:0] v;
    push_move(0);
    pulse_count(3'd0, 1'b1);
    wait_done("home2");
    for (int a = 89; a >= 70; a--) exp_q.push_back({2'd0, 8'(a)});
    pulse_count(3'd1, 1'b1);
    wait_base(8'd70, "reach_70");
    for (int a = 71; a <= 135; a++) exp_q.push_back({2'd0, 8'(a)});
    pulse_count(3'd2, 1'b1);
    wait_base(8'd100, "reach_100");
    @(negedge clk);
    hold = 1'b1;
    v = angle_base;
    repeat (50) @(negedge clk);
    checks++;
    if (angle_base !== v || v !== 8'd100 || busy !== 1'b1 || active_servo !== 2'd0) begin
      errors++;
      $display("FAIL hold_freeze: base %0d busy %b active %0d, required 100 1 0", angle_base, busy, active_servo);
    end
    hold = 1'b0;
    m_ang[0] = 8'd135;
    m_last = 0;
    wait_done("retarget");
  endtask

  task automatic test_ignored();
    int b = 0;
    pulse_count(3'd6, 1'b1);
    repeat (20) begin @(negedge clk); if (busy) b++; end
    checks++;
    if (b != 0) begin
      errors++;
      $display("FAIL count6_ignored: busy for %0d cycles, required 0", b);
    end
    pulse_count(3'd3, 1'b0);
    hand_detected = 1'b1;
    repeat (20) begin @(negedge clk); if (busy) b++; end
    checks++;
    if (b != 0 || angle_base !== 8'd135) begin
      errors++;
      $display("FAIL no_hand_ignored: busy cycles %0d base %0d, required 0 135", b, angle_base);
    end
  endtask

  task automatic test_reset_mid();
    push_move(4);
    pulse_count(3'd4, 1'b1);
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({angle_base, angle_shoulder, angle_elbow, angle_gripper} !== {4{8'd90}} ||
        {busy, pose_done, active_servo} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: %0d/%0d/%0d/%0d busy %b active %0d, required all 90 busy 0 active 0",
               angle_base, angle_shoulder, angle_elbow, angle_gripper, busy, active_servo);
    end
    exp_q.delete();
    for (int j = 0; j < 4; j++) m_ang[j] = 8'd90;
    m_last = 3;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy %b, required 0", busy);
    end
  endtask

  task automatic test_safe_home();
    int first = -1;
    push_move(5);
    pulse_count(3'd5, 1'b1);
    wait_done("pose5");
`ifdef SAFE_HOME_EN
    push_move(0);
`endif
    @(negedge clk);
    hand_detected = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (busy && first < 0) first = cyc;
    end
`ifdef SAFE_HOME_EN
    checks++;
    if (first != 101) begin
      errors++;
      $display("FAIL loss_timeout: busy rose at cycle %0d, required 101", first);
    end
    wait_done("safe_home");
`else
    checks++;
    if (first != -1 || angle_gripper !== 8'd30) begin
      errors++;
      $display("FAIL hand_loss_hold: busy at %0d gripper %0d, required never 30", first, angle_gripper);
    end
`endif
    hand_detected = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_joint();
    test_round_robin();
    test_retarget_hold();
    test_ignored();
    test_reset_mid();
    test_safe_home();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
